pirdsp_mult_sched: RTL and testbench

Round-robin scheduler that shares one pirdsp2 multiplier instance among NUM_REQ requesters. Each request carries its own SIMD precision code (MULTMODE). When a request needs a different MULTMODE from the one currently loaded, the scheduler drains the DSP pipeline, reconfigures the DSP, and only then issues the request. It tags each issued operation so that the DSP P output is returned to the requester that issued it, after a fixed latency.

---
 rtl/pirdsp_mult_sched_if.sv | 31 +++
 rtl/pirdsp_mult_sched.sv | 138 +++++++++++++
 tb/tb_pirdsp_mult_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pirdsp_mult_sched_if.sv
// rtl/pirdsp_mult_sched_if.sv - requester, DSP and response signals of the multiplier scheduler
interface pirdsp_mult_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*54-1:0] req_a;
    logic [NUM_REQ*54-1:0] req_b;
    logic [NUM_REQ*4-1:0]  req_mode;
    logic [53:0]           dsp_a;
    logic [53:0]           dsp_b;
    logic [3:0]            dsp_multmode;
    logic                  dsp_issue;
    logic [47:0]           dsp_p;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [47:0]           resp_data;
    logic [3:0]            cur_mode;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, req_mode, dsp_p,
        input  req_ready, dsp_a, dsp_b, dsp_multmode, dsp_issue,
        input  resp_valid, resp_data, cur_mode, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_mode, dsp_p,
        output req_ready, dsp_a, dsp_b, dsp_multmode, dsp_issue,
        output resp_valid, resp_data, cur_mode, busy
    );
endinterface

// File: rtl/pirdsp_mult_sched.sv
// rtl/pirdsp_mult_sched.sv - round-robin scheduler sharing one pirdsp2 multiplier across requesters
module pirdsp_mult_sched #(
    parameter int         NUM_REQ      = 4,
    parameter int         DSP_LAT      = 3,
    parameter int         SWITCH_GAP   = 2,
    parameter logic [3:0] DEFAULT_MODE = 4'b0111
) (
    input logic                  CLK,
    input logic                  RST,
    pirdsp_mult_sched_if.slave   bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(SWITCH_GAP + 1) + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWITCH} state_t;

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_rr_ptr;
    logic                r_lock_v;
    logic [PW-1:0]       r_lock_id;
    logic [3:0]          r_new_mode, r_cur_mode, r_dsp_multmode;
    logic [GW-1:0]       r_gap_cnt;
    logic [53:0]         r_dsp_a, r_dsp_b;
    logic                r_iss_v;
    logic [PW-1:0]       r_iss_id;
    logic [DSP_LAT-1:0]  r_tag_v;
    logic [PW-1:0]       r_tag_id [DSP_LAT];

    logic                w_win_v;
    logic [PW-1:0]       w_win_id;
    logic [PW:0]         w_idx;
    logic [3:0]          w_win_mode;
    logic                w_match, w_hs, w_pipe_empty;

    // The locked requester keeps exclusive claim while it is still asking.
    always_comb begin
        w_win_v  = 1'b0;
        w_win_id = '0;
        w_idx    = '0;
        if (r_lock_v && bus.req_valid[r_lock_id]) begin
            w_win_v  = 1'b1;
            w_win_id = r_lock_id;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
                if (w_idx >= (PW+1)'(NUM_REQ))
                    w_idx = w_idx - (PW+1)'(NUM_REQ);
                if (!w_win_v && bus.req_valid[w_idx[PW-1:0]]) begin
                    w_win_v  = 1'b1;
                    w_win_id = w_idx[PW-1:0];
                end
            end
        end
    end

    assign w_win_mode   = bus.req_mode[int'(w_win_id)*4 +: 4];
    assign w_match      = (w_win_mode == r_cur_mode);
    assign w_hs         = (r_state == ST_RUN) && w_win_v && w_match;
    assign w_pipe_empty = !r_iss_v && (r_tag_v == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_win_v && !w_match) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_pipe_empty) w_state_nxt = ST_SWITCH;
            ST_SWITCH: if (r_gap_cnt <= GW'(1)) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state        <= ST_RUN;
            r_rr_ptr       <= '0;
            r_lock_v       <= 1'b0;
            r_lock_id      <= '0;
            r_new_mode     <= DEFAULT_MODE;
            r_cur_mode     <= DEFAULT_MODE;
            r_dsp_multmode <= DEFAULT_MODE;
            r_gap_cnt      <= '0;
            r_dsp_a        <= '0;
            r_dsp_b        <= '0;
            r_iss_v        <= 1'b0;
            r_iss_id       <= '0;
            r_tag_v        <= '0;
            for (int i = 0; i < DSP_LAT; i++) r_tag_id[i] <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_iss_v  <= w_hs;
            r_iss_id <= w_win_id;
            // Tag pipe trails the issue register so the id lines up with dsp_p.
            r_tag_v     <= (r_tag_v << 1) | DSP_LAT'(r_iss_v);
            r_tag_id[0] <= r_iss_id;
            for (int i = 1; i < DSP_LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
            case (r_state)
                ST_RUN: begin
                    if (w_hs) begin
                        r_dsp_a  <= bus.req_a[int'(w_win_id)*54 +: 54];
                        r_dsp_b  <= bus.req_b[int'(w_win_id)*54 +: 54];
                        r_rr_ptr <= (w_win_id == PW'(NUM_REQ-1)) ? '0 : w_win_id + PW'(1);
                        r_lock_v <= 1'b0;
                    end else if (w_win_v) begin
                        r_new_mode <= w_win_mode;
                        r_lock_v   <= 1'b1;
                        r_lock_id  <= w_win_id;
                    end else begin
                        r_lock_v <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_dsp_multmode <= r_new_mode;
                        r_gap_cnt      <= GW'(SWITCH_GAP);
                    end
                end
                ST_SWITCH: begin
                    if (r_gap_cnt <= GW'(1)) begin
                        r_cur_mode <= r_new_mode;
                        r_lock_v   <= r_lock_v && bus.req_valid[r_lock_id];
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = w_hs ? (NUM_REQ'(1) << w_win_id) : '0;
    assign bus.dsp_a        = r_dsp_a;
    assign bus.dsp_b        = r_dsp_b;
    assign bus.dsp_multmode = r_dsp_multmode;
    assign bus.dsp_issue    = r_iss_v;
    assign bus.resp_valid   = r_tag_v[DSP_LAT-1] ? (NUM_REQ'(1) << r_tag_id[DSP_LAT-1]) : '0;
    assign bus.resp_data    = r_tag_v[DSP_LAT-1] ? bus.dsp_p : '0;
    assign bus.cur_mode     = r_cur_mode;
    assign bus.busy         = r_iss_v || (r_tag_v != '0) || (r_state != ST_RUN);
endmodule

// File: tb/tb_pirdsp_mult_sched.sv
// tb/tb_pirdsp_mult_sched.sv - directed-vector bench for pirdsp_mult_sched
module tb_pirdsp_mult_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    pirdsp_mult_sched_if #(.NUM_REQ(4)) bus ();

    pirdsp_mult_sched #(
        .NUM_REQ(4), .DSP_LAT(3), .SWITCH_GAP(2), .DEFAULT_MODE(4'b0111)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Three-stage DSP model: product of the issued operands appears three cycles later.
    logic [107:0] prod;
    logic [47:0]  p1, p2, p3;
    assign prod = bus.dsp_a * bus.dsp_b;
    always @(posedge clk) begin
        p1 <= prod[47:0];
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.dsp_p = p3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [53:0] a, input logic [53:0] b, input logic [3:0] m);
        bus.req_a[i*54 +: 54] = a;
        bus.req_b[i*54 +: 54] = b;
        bus.req_mode[i*4 +: 4] = m;
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
    endtask

    logic [3:0]  vld_t  [16];
    logic [3:0]  rdy_t  [16];
    logic [3:0]  rsp_t  [16];
    logic [47:0] dat_t  [16];
    logic [3:0]  seen;

    task automatic clear_tables();
        for (int c = 0; c < 16; c++) begin
            vld_t[c] = '0; rdy_t[c] = '0; rsp_t[c] = '0; dat_t[c] = '0;
        end
    endtask

    task automatic run_table(input string tag, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            bus.req_valid = vld_t[c];
            #1;
            check($sformatf("%s_rdy_c%0d", tag, c), 64'(bus.req_ready), 64'(rdy_t[c]));
            check($sformatf("%s_rsp_c%0d", tag, c), 64'(bus.resp_valid), 64'(rsp_t[c]));
            if (rsp_t[c] != 0)
                check($sformatf("%s_dat_c%0d", tag, c), 64'(bus.resp_data), 64'(dat_t[c]));
            tick();
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_mode = '0;
        tick();
        tick();
        #2 rst = 1'b0;
        tick();

        check("rst_ready",    64'(bus.req_ready),    64'h0);
        check("rst_issue",    64'(bus.dsp_issue),    64'h0);
        check("rst_resp",     64'(bus.resp_valid),   64'h0);
        check("rst_data",     64'(bus.resp_data),    64'h0);
        check("rst_busy",     64'(bus.busy),         64'h0);
        check("rst_dsp_a",    64'(bus.dsp_a),        64'h0);
        check("rst_curmode",  64'(bus.cur_mode),     64'h7);
        check("rst_multmode", 64'(bus.dsp_multmode), 64'h7);

        // Single op: 3*5 handshake in cycle 0, issue in cycle 1, result in cycle 4.
        set_op(0, 54'd3, 54'd5, 4'b0111);
        bus.req_valid = 4'b0001;
        #1;
        check("single_ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 4'b0000;
        #1;
        check("single_issue", 64'(bus.dsp_issue), 64'h1);
        check("single_dsp_a", 64'(bus.dsp_a), 64'd3);
        check("single_dsp_b", 64'(bus.dsp_b), 64'd5);
        check("single_busy",  64'(bus.busy), 64'h1);
        check("single_rsp_c1", 64'(bus.resp_valid), 64'h0);
        tick();
        check("single_rsp_c2", 64'(bus.resp_valid), 64'h0);
        tick();
        check("single_rsp_c3", 64'(bus.resp_valid), 64'h0);
        tick();
        check("single_rsp_c4",  64'(bus.resp_valid), 64'h1);
        check("single_data_c4", 64'(bus.resp_data), 64'd15);
        tick();
        check("single_rsp_c5",  64'(bus.resp_valid), 64'h0);
        check("single_idle",    64'(bus.busy), 64'h0);

        // Round-robin: all four valid, same mode, operands (i+2)*(10+i).
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 54'(i + 2), 54'(10 + i), 4'b0111);
        clear_tables();
        for (int c = 0; c < 6; c++) begin
            vld_t[c] = 4'hF;
            rdy_t[c] = 4'(1 << (c % 4));
        end
        for (int c = 4; c < 10; c++) begin
            rsp_t[c] = 4'(1 << ((c - 4) % 4));
            dat_t[c] = 48'((((c - 4) % 4) + 2) * (10 + ((c - 4) % 4)));
        end
        run_table("rr", 11);

        // Mode switch: req0 mode 7 issued, then req1/req2 want mode 3.
        do_reset();
        set_op(0, 54'd3,  54'd5,  4'b0111);
        set_op(1, 54'd7,  54'd9,  4'b0011);
        set_op(2, 54'd11, 54'd13, 4'b0011);
        set_op(3, 54'd0,  54'd0,  4'b0111);
        clear_tables();
        vld_t[0] = 4'b0001;
        for (int c = 1; c <= 8; c++) vld_t[c] = 4'b0110;
        vld_t[9] = 4'b0100;
        rdy_t[0] = 4'b0001; rdy_t[8] = 4'b0010; rdy_t[9] = 4'b0100;
        rsp_t[4] = 4'b0001; dat_t[4] = 48'd15;
        rsp_t[12] = 4'b0010; dat_t[12] = 48'd63;
        rsp_t[13] = 4'b0100; dat_t[13] = 48'd143;
        for (int c = 0; c < 15; c++) begin
            bus.req_valid = vld_t[c];
            #1;
            check($sformatf("sw_rdy_c%0d", c), 64'(bus.req_ready), 64'(rdy_t[c]));
            check($sformatf("sw_rsp_c%0d", c), 64'(bus.resp_valid), 64'(rsp_t[c]));
            if (rsp_t[c] != 0)
                check($sformatf("sw_dat_c%0d", c), 64'(bus.resp_data), 64'(dat_t[c]));
            if (c == 5) check("sw_multmode_c5", 64'(bus.dsp_multmode), 64'h7);
            if (c == 6) check("sw_multmode_c6", 64'(bus.dsp_multmode), 64'h3);
            if (c == 7) check("sw_curmode_c7",  64'(bus.cur_mode), 64'h7);
            if (c == 7) check("sw_busy_c7",     64'(bus.busy), 64'h1);
            if (c == 8) check("sw_curmode_c8",  64'(bus.cur_mode), 64'h3);
            if (c == 9) check("sw_dsp_a_c9",    64'(bus.dsp_a), 64'd7);
            tick();
        end

        // Wrap: rr_ptr is now 3, requests on 1 and 3 (mode 3 loaded).
        set_op(1, 54'd2, 54'd4, 4'b0011);
        set_op(3, 54'd6, 54'd8, 4'b0011);
        clear_tables();
        vld_t[0] = 4'b1010; rdy_t[0] = 4'b1000;
        vld_t[1] = 4'b0010; rdy_t[1] = 4'b0010;
        rsp_t[4] = 4'b1000; dat_t[4] = 48'd48;
        rsp_t[5] = 4'b0010; dat_t[5] = 48'd8;
        run_table("wrap", 8);

        // Async reset mid-cycle with two ops in flight; mode 3 still loaded.
        set_op(0, 54'd5, 54'd5, 4'b0011);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        #2 rst = 1'b1;
        #1;
        check("arst_issue",    64'(bus.dsp_issue),    64'h0);
        check("arst_busy",     64'(bus.busy),         64'h0);
        check("arst_resp",     64'(bus.resp_valid),   64'h0);
        check("arst_dsp_a",    64'(bus.dsp_a),        64'h0);
        check("arst_curmode",  64'(bus.cur_mode),     64'h7);
        check("arst_multmode", 64'(bus.dsp_multmode), 64'h7);
        tick();
        #2 rst = 1'b0;
        seen = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            seen = seen | bus.resp_valid;
        end
        check("arst_no_resp", 64'(seen), 64'h0);

        // Locked requester withdraws during SWITCH; req0 then wins normally.
        do_reset();
        set_op(0, 54'd4, 54'd4, 4'b0011);
        set_op(2, 54'd9, 54'd9, 4'b0011);
        clear_tables();
        vld_t[0] = 4'b0100;
        vld_t[1] = 4'b0101; vld_t[2] = 4'b0101;
        vld_t[3] = 4'b0001; vld_t[4] = 4'b0001;
        rdy_t[4] = 4'b0001;
        rsp_t[8] = 4'b0001; dat_t[8] = 48'd16;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = vld_t[c];
            #1;
            check($sformatf("wd_rdy_c%0d", c), 64'(bus.req_ready), 64'(rdy_t[c]));
            check($sformatf("wd_rsp_c%0d", c), 64'(bus.resp_valid), 64'(rsp_t[c]));
            if (rsp_t[c] != 0)
                check($sformatf("wd_dat_c%0d", c), 64'(bus.resp_data), 64'(dat_t[c]));
            if (c == 2) check("wd_busy_c2",    64'(bus.busy), 64'h1);
            if (c == 3) check("wd_curmode_c3", 64'(bus.cur_mode), 64'h7);
            if (c == 4) check("wd_curmode_c4", 64'(bus.cur_mode), 64'h3);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
